// File: rtl/stopwatch_pkg.sv
// Shared types, segment patterns and digit helpers
// for the lap stopwatch.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE
   } sw_state_e;

   typedef struct packed {
      logic [6:0] hr;
      logic [5:0] mn;
      logic [5:0] sc;
   } sw_time_t;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;

   function automatic logic [6:0] seg_decode(
      input logic [3:0] digit,
      input logic       active_low
   );
      logic [6:0] p;
      case (digit)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = 7'h00;
      endcase
      return active_low ? ~p : p;
   endfunction

   function automatic logic [7:0] bin_to_bcd2(
      input logic [6:0] v
   );
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

endpackage

// File: rtl/sw_sync_edge.sv
// Two-flop synchroniser with a rising-edge pulse;
// a level already high at reset release is not an edge.
module sw_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic rise_o
);

   logic       s1_q;
   logic       s2_q;
   logic       prev_q;
   logic [1:0] fill_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
         fill_q <= 2'b00;
      end else begin
         s1_q   <= d_i;
         s2_q   <= s1_q;
         fill_q <= {fill_q[0], 1'b1};
         // while filling, track the first stage so a held level never pulses
         prev_q <= fill_q[1] ? s2_q : s1_q;
      end
   end

   assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/lap_stopwatch.sv
// HH:MM:SS stopwatch with prescaler, lap hold and
// clear-while-paused, driving six 7-segment digits.
module lap_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV       = 100,
   parameter int HOUR_MAX       = 24,
   parameter bit SEG_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_stop,
   input  logic       lap_clr,
   output logic [6:0] h10,
   output logic [6:0] h1,
   output logic [6:0] m10,
   output logic [6:0] m1,
   output logic [6:0] s10,
   output logic [6:0] s1,
   output logic       running,
   output logic       lap_active
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [6:0] HR_LAST = 7'(HOUR_MAX - 1);
   localparam logic [6:0] SEG_RST = seg_decode(4'd0, SEG_ACTIVE_LOW);

   logic            ss_ev;
   logic            lc_raw;
   logic            lc_ev;
   logic            clr;
   sw_state_e       state_q;
   logic            run_q;
   logic            lap_q;
   sw_time_t        snap_q;
   sw_time_t        cnt_q;
   sw_time_t        cnt_d;
   logic [PW-1:0]   pre_q;
   logic [PW-1:0]   pre_d;
   sw_time_t        disp;
   logic [7:0]      hb;
   logic [7:0]      mb;
   logic [7:0]      sb;
   logic [5:0][6:0] seg_q;
   logic [5:0][6:0] seg_d;

   sw_sync_edge u_ss (
      .clk    (clk),
      .rst_n  (rst),
      .d_i    (start_stop),
      .rise_o (ss_ev)
   );

   sw_sync_edge u_lc (
      .clk    (clk),
      .rst_n  (rst),
      .d_i    (lap_clr),
      .rise_o (lc_raw)
   );

   assign lc_ev = lc_raw & ~ss_ev;
   assign clr   = lc_ev & (state_q == PAUSE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         run_q   <= 1'b0;
         lap_q   <= 1'b0;
         snap_q  <= '0;
      end else if (ss_ev) begin
         unique case (state_q)
            RUN: begin
               state_q <= PAUSE;
               run_q   <= 1'b0;
            end
            default: begin
               state_q <= RUN;
               run_q   <= 1'b1;
            end
         endcase
      end else if (lc_ev) begin
         unique case (state_q)
            RUN: begin
               lap_q <= ~lap_q;
               if (!lap_q) snap_q <= cnt_q;
            end
            PAUSE: begin
               state_q <= IDLE;
               lap_q   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      if (clr) begin
         pre_d = '0;
         cnt_d = '0;
      end else if (state_q == RUN) begin
         if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (cnt_q.sc == 6'd59) begin
               cnt_d.sc = '0;
               if (cnt_q.mn == 6'd59) begin
                  cnt_d.mn = '0;
                  if (cnt_q.hr == HR_LAST) cnt_d.hr = '0;
                  else cnt_d.hr = cnt_q.hr + 7'd1;
               end else begin
                  cnt_d.mn = cnt_q.mn + 6'd1;
               end
            end else begin
               cnt_d.sc = cnt_q.sc + 6'd1;
            end
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign disp = lap_q ? snap_q : cnt_q;
   assign hb   = bin_to_bcd2(disp.hr);
   assign mb   = bin_to_bcd2({1'b0, disp.mn});
   assign sb   = bin_to_bcd2({1'b0, disp.sc});

   assign seg_d = {
      seg_decode(hb[7:4], SEG_ACTIVE_LOW),
      seg_decode(hb[3:0], SEG_ACTIVE_LOW),
      seg_decode(mb[7:4], SEG_ACTIVE_LOW),
      seg_decode(mb[3:0], SEG_ACTIVE_LOW),
      seg_decode(sb[7:4], SEG_ACTIVE_LOW),
      seg_decode(sb[3:0], SEG_ACTIVE_LOW)
   };

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) seg_q <= {6{SEG_RST}};
      else      seg_q <= seg_d;
   end

   assign {h10, h1, m10, m1, s10, s1} = seg_q;
   assign running    = run_q;
   assign lap_active = lap_q;

endmodule
